// File: rtl/dem4b_ctrl_if.sv
// Control and status bundle for the 4-bit counter sequencer.
// The master side holds the buttons and switches; the slave side is the sequencer.
interface dem4b_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       dir;
    logic [3:0] limit;
    logic       auto_reload;
    logic [3:0] Q;
    logic       tick;
    logic       tc;
    logic       running;
    logic       done;

    modport master (
        output start, stop, clear, load, load_val, dir, limit, auto_reload,
        input  Q, tick, tc, running, done
    );

    modport slave (
        input  start, stop, clear, load, load_val, dir, limit, auto_reload,
        output Q, tick, tc, running, done
    );
endinterface

// File: rtl/dem4b_ctrl.sv
// Single-clock sequencer for the 4-bit counter: a prescaler issues a one-cycle step
// enable, and a small IDLE/RUN/PAUSE/DONE machine gates stepping, loading and restarts.
module dem4b_ctrl #(
    parameter int DIV = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    dem4b_ctrl_if.slave     bus
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    q_q, q_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          tc_q, tc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic          step;
    logic          terminal;
    logic          restart;
    logic [3:0]    start_val;
    logic [3:0]    load_clip;

    // Event decode shared by the next-state and datapath processes.
    assign start_val = bus.dir ? bus.limit : 4'd0;
    assign load_clip = (bus.load_val < bus.limit) ? bus.load_val : bus.limit;
    assign terminal  = bus.dir ? (q_q == 4'd0) : (q_q >= bus.limit);
    assign restart   = !bus.clear && !bus.load && !bus.stop && bus.start && (state_q != S_RUN);
    assign step      = !bus.clear && !bus.load && !bus.stop && (state_q == S_RUN)
                       && (presc_q == PRESC_LAST);

    // NOTE: state lives only in this block and uses non-blocking assignments so every
    // flop samples the values computed before the edge; the comb blocks use blocking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            q_q       <= 4'd0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else if (bus.load) begin
            if (state_q == S_DONE) state_d = S_IDLE;
        end else if (bus.stop) begin
            if (state_q == S_RUN) state_d = S_PAUSE;
        end else if (restart) begin
            state_d = S_RUN;
        end else if (step && terminal && !bus.auto_reload) begin
            state_d = S_DONE;
        end
    end

    always_comb begin
        q_d     = q_q;
        presc_d = presc_q;
        if (bus.clear) begin
            q_d     = 4'd0;
            presc_d = '0;
        end else if (bus.load) begin
            q_d     = load_clip;
            presc_d = '0;
        end else if (bus.stop) begin
            presc_d = presc_q;
        end else if (restart) begin
            // Resuming from PAUSE keeps the partially elapsed step period.
            if (state_q == S_DONE) q_d = start_val;
            if (state_q != S_PAUSE) presc_d = '0;
        end else if (state_q == S_RUN) begin
            if (step) begin
                presc_d = '0;
                if (!terminal) begin
                    q_d = bus.dir ? (q_q - 4'd1) : (q_q + 4'd1);
                end else if (bus.auto_reload) begin
                    q_d = start_val;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        tick_d    = step;
        tc_d      = step && terminal;
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    assign bus.Q       = q_q;
    assign bus.tick    = tick_q;
    assign bus.tc      = tc_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: doc/dem4b_ctrl.md
Name: dem4b_ctrl

Overview:
- Sequencer for the team's 4-bit counter datapath.
- Replaces the derived-clock pattern (counter clocked from a divided tick) with a single-clock design: internal prescaler produces a one-cycle tick enable; the count register steps only on tick.
- Adds run/pause/done control, up/down direction, programmable terminal value, parallel load, and one-shot or auto-reload operation.
- Sits between board buttons/switches and the 4-bit display/LED path.

Parameters:
- DIV, 50000000, clk cycles per count step (1 Hz at 50 MHz); legal range DIV >= 2; prescaler width = clog2(DIV).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level, synchronous; run/resume/restart request.
- stop  input  1  level, synchronous; pause request.
- clear  input  1  level, synchronous; return to IDLE with Q=0.
- load  input  1  level, synchronous; parallel load of load_val.
- load_val  input  4  value for load.
- dir  input  1  0 = count up, 1 = count down.
- limit  input  4  terminal value; up counts 0..limit, down counts limit..0.
- auto_reload  input  1  1 = wrap at terminal; 0 = stop in DONE.
- Q  output  4  count value (registered).
- tick  output  1  one-cycle pulse when a step occurs (registered).
- tc  output  1  one-cycle pulse when a terminal step occurs (wrap or entry to DONE).
- running  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (reset=0, async): state=IDLE, Q=0, prescaler=0; tick, tc, running and done all 0.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN); done = (state==DONE). Both are registered, consistent with state.
- Per-cycle priority: clear > load > stop > start > step.
- clear, in any state: state=IDLE, Q=0, prescaler=0 next edge.
- load, in any state:
  - Q = min(load_val, limit); prescaler=0.
  - RUN stays RUN. DONE goes to IDLE. IDLE and PAUSE are unchanged.
- Transitions:
  - IDLE: start -> RUN with prescaler=0.
  - RUN: stop -> PAUSE; prescaler holds its value.
  - PAUSE: start (stop low) -> RUN; prescaler resumes from its held value.
  - DONE: start -> RUN with Q reset to its start value (0 if dir=0, limit if dir=1) and prescaler=0.
- Prescaler:
  - Increments only in RUN.
  - When prescaler==DIV-1 and no higher-priority event: prescaler=0 and a step occurs.
  - tick=1 on the edge the new Q appears.
- Step, dir=0 (up):
  - If Q >= limit (terminal): auto_reload=1 -> Q=0, tc=1, stay RUN; auto_reload=0 -> Q holds, tc=1, state=DONE.
  - Otherwise Q=Q+1.
- Step, dir=1 (down):
  - If Q==0 (terminal): auto_reload=1 -> Q=limit, tc=1; auto_reload=0 -> Q holds at 0, tc=1, state=DONE.
  - Otherwise Q=Q-1.
- Arithmetic and input changes:
  - Q arithmetic is 4-bit; Q never exceeds 15.
  - limit=0: every step is terminal.
  - dir, limit and auto_reload are sampled at the step cycle; changing them mid-run is legal and takes effect on the next step.
- Latency:
  - start sampled at edge N -> running=1 from edge N.
  - First step from IDLE at edge N+DIV (Q and tick update together).
- Simultaneous start and stop: stop wins (PAUSE, or stays PAUSE).
- Held start in RUN: no effect. Held start in DONE: restarts once, then counts normally.
- Mid-operation reset: immediate async return to reset values regardless of state or prescaler.
- tick and tc: exactly one cycle wide; never asserted outside a step.

Test Plan (DIV=4):
- Reset release, then start for 1 cycle, dir=0, limit=15, auto_reload=1:
  - Q steps 0,1,2,... every 4 clk with a tick pulse each step.
  - After 16 steps Q=0 with tc=1 for one cycle.
- dir=0, limit=5, auto_reload=0, start:
  - Q reaches 5; the next step gives tc=1, done=1, running=0, and Q holds 5.
  - start again: Q=0 and counting resumes.
- dir=1, limit=9, auto_reload=1, load with load_val=3, then start:
  - Q sequence 3,2,1,0,9,8; tc pulses on the 0->9 step.
- RUN with prescaler=2: stop for 5 cycles, then start:
  - Q is frozen during the pause.
  - The next step occurs 2 cycles after resume (prescaler preserved).
- load_val=12 with limit=7: Q=7. Then clear together with load and start: Q=0, state IDLE.
- Drive reset low mid-count (Q=6, RUN):
  - Q=0 and all outputs 0 immediately, without waiting for clk.
  - After release, the block stays IDLE until start.
